post_hash_pe_gatherer: RTL
==========================

# post_hash_pe_gatherer

Reassembles per-PE hash-PE results back into full issue windows. Sits downstream of the hash PE array, at the opposite end of the pre-hash scheduling path. That path splits each `HASH_ISSUE_WIDTH` window into per-bank requests. This block collects the per-lane results into two window buffers indexed by address. It emits each window in address order, as one `HASH_ISSUE_WIDTH`-wide vector with its head address and delimiter.

## Interface
- `HASH_ISSUE_WIDTH`, 32: positions per window; power of two; `W_LOG2` = log2 of it.
- `NUM_HASH_PE`, 16: result lanes per cycle.
- `ADDR_WIDTH`, 32: byte address width.
- `RESULT_W`, 32: per-position result width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `input_valid` in 1: lane bundle valid.
- `input_mask` in `NUM_HASH_PE`: lane i carries a result.
- `input_addr` in `NUM_HASH_PE*ADDR_WIDTH`: position address per lane.
- `input_result` in `NUM_HASH_PE*RESULT_W`: result per lane.
- `input_delim` in `NUM_HASH_PE`: lane belongs to a stream-final window.
- `input_ready` out 1: bundle accepted when valid&ready.
- `output_valid` out 1: a complete window is presented.
- `output_head_addr` out `ADDR_WIDTH`: window head; low `W_LOG2` bits are 0.
- `output_result_vec` out `HASH_ISSUE_WIDTH*RESULT_W`: slot j = result for head+j.
- `output_delim` out 1: OR of `input_delim` over the window's lanes.
- `output_ready` in 1: window consumed when valid&ready.

## Operation
- Lane decode:
  - slot = `addr[W_LOG2-1:0]`.
  - head = addr with the low `W_LOG2` bits cleared.
  - bank = `addr[W_LOG2]`.
- Two banks, each holding:
  - state EMPTY/FILLING/FULL;
  - head;
  - fill count (`W_LOG2+1` bits);
  - per-slot filled bitmap;
  - delim flag;
  - `HASH_ISSUE_WIDTH` result slots.
- Upstream guarantees:
  - lanes in one bundle span at most two consecutive windows;
  - each position appears exactly once.
- A lane is admissible when its bank is either:
  - EMPTY, or
  - FILLING with an equal head.
- A lane targeting a FULL bank, or a FILLING bank with a different head, is blocked.
- `input_ready` = no masked lane is blocked. The bundle is all-or-nothing; there is no partial accept.
- On accept, per masked lane:
  - write the slot and set its filled bit;
  - load the bank head if the bank was EMPTY;
  - OR the lane's delim into the bank delim flag.
- Per bank, count += popcount of accepted lanes mapped to it. EMPTY→FILLING; count==`HASH_ISSUE_WIDTH` → FULL (EMPTY→FULL directly if a single bundle fills it).
- Read pointer `rd` (1 bit):
  - when both banks are EMPTY and a bundle is accepted, `rd` loads the bank bit of the lowest accepted address;
  - otherwise `rd` toggles on each output handshake.
- `output_valid` = (bank[rd] == FULL). Outputs are driven directly from bank[rd] registers.
- Output handshake: bank[rd] → EMPTY (count, bitmap and delim cleared), and `rd` toggles.
- Assertions (simulation only):
  - a write to an already-filled slot;
  - count overflow;
  - bank[!rd] FULL while bank[rd] is EMPTY.

## Timing
- Reset (async):
  - all outputs 0 (`output_valid`=0, `output_head_addr`=0, `output_result_vec`=0, `output_delim`=0);
  - `input_ready`=1;
  - banks EMPTY, slot storage 0, `rd`=0.
- Latency: a bundle completing a window at edge t gives `output_valid`=1 after edge t (visible in cycle t+1).
- `output_valid` and its payload hold stable until `output_ready`.
- `input_ready` is combinational from bank state and the current input; it has no path from `output_ready`.
- Same-cycle output handshake and input targeting the dequeuing bank: input is blocked that cycle (bank still FULL) and accepted the next cycle. This one-cycle bubble is the accepted cost.
- Same-cycle output handshake and input into the other bank: both proceed.
- Both banks FULL: `input_ready`=0 for any masked lane.
- `input_valid` with all-zero mask: accepted, no state change.
- Reset mid-window: partial windows are discarded; no output is produced for them.

## Structure
- Shared package / `parameters.vh` holds:
  - the `HASH_ISSUE_WIDTH`, `NUM_HASH_PE`, `ADDR_WIDTH` macros;
  - the `RESULT_W` macro;
  - bank state encodings EMPTY=2'd0, FILLING=2'd1, FULL=2'd2.
- Sub-module `gather_window_bank` is instantiated twice. It contains:
  - slot storage, bitmap, count, head and delim;
  - the `can_accept(head)` and full outputs.
- The top level contains lane decode, admissibility, `rd` and the output mux.

## Test plan
Run with `HASH_ISSUE_WIDTH`=4, `NUM_HASH_PE`=2, `RESULT_W`=8.

- **In-order fill.** Bundles (mask 11, addr 0x40/0x41, res AA/BB) then (11, 0x42/0x43, CC/DD). Expect next cycle:
  - `output_valid`=1, head 0x40, vec {DD,CC,BB,AA}, delim 0.
- **Split bundle across windows.** Lanes 0x43 and 0x44 in one bundle after 0x40–0x42. Expect:
  - window 0x40 emitted first;
  - bank1 FILLING with head 0x44;
  - `input_ready` stays 1.
- **Backpressure.** Hold `output_ready`=0 with both banks FULL, then offer lane 0x48. Expect:
  - `input_ready`=0 until one handshake;
  - one bubble cycle, then accept.
- **Head conflict.** Bank0 FILLING head 0x40, offer lane 0x48. Expect `input_ready`=0 until 0x40 emits.
- **Delim.** Single lane of window 0x4C carries delim=1. Expect `output_delim`=1 only on that window.
- **Reset.** Assert `rst_n` low mid-window with 2 slots filled. Expect:
  - all outputs 0 immediately;
  - after release, first window from address 0x84 emits with head 0x84 and `rd`=1.

Source files
------------

// File: rtl/post_hash_pe_gatherer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : post_hash_pe_gatherer_pkg
// Description : Shared sizing constants and window-bank state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package post_hash_pe_gatherer_pkg;

  localparam int C_HASH_ISSUE_WIDTH = 32;
  localparam int C_NUM_HASH_PE      = 16;
  localparam int C_ADDR_WIDTH       = 32;
  localparam int C_RESULT_W         = 32;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

endpackage : post_hash_pe_gatherer_pkg
`default_nettype wire

// File: rtl/post_hash_pe_gatherer_gather_window_bank.sv
`default_nettype none
// ============================================================================
// Module      : gather_window_bank
// Description : One window buffer: result slots, filled bitmap, count, head,
//               delimiter flag and EMPTY/FILLING/FULL state.
// Revision    : 1.0 - initial release
// ============================================================================
module gather_window_bank
  import post_hash_pe_gatherer_pkg::*;
#(
  parameter int HASH_ISSUE_WIDTH = C_HASH_ISSUE_WIDTH,
  parameter int NUM_HASH_PE      = C_NUM_HASH_PE,
  parameter int ADDR_WIDTH       = C_ADDR_WIDTH,
  parameter int RESULT_W         = C_RESULT_W,
  localparam int W_LOG2          = $clog2(HASH_ISSUE_WIDTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [NUM_HASH_PE-1:0]             lane_hit,
  input  logic [NUM_HASH_PE*W_LOG2-1:0]      lane_slot,
  input  logic [NUM_HASH_PE*RESULT_W-1:0]    lane_result,
  input  logic [NUM_HASH_PE-1:0]             lane_delim,
  input  logic [ADDR_WIDTH-1:0]              req_head,
  input  logic                               deq,
  output logic                               can_accept,
  output logic                               full,
  output logic [1:0]                         state,
  output logic [ADDR_WIDTH-1:0]              head,
  output logic                               delim,
  output logic [HASH_ISSUE_WIDTH*RESULT_W-1:0] result_vec
);

  localparam int CW = W_LOG2 + 1;

  bank_state_t                          r_state;
  logic [ADDR_WIDTH-1:0]                r_head;
  logic [CW-1:0]                        r_count;
  logic [HASH_ISSUE_WIDTH-1:0]          r_bitmap;
  logic                                 r_delim;
  logic [HASH_ISSUE_WIDTH*RESULT_W-1:0] r_slots;

  logic [CW-1:0]                        w_pop;
  logic [CW:0]                          w_sum;
  logic                                 w_delim_in;
  logic                                 w_dup;
  logic [HASH_ISSUE_WIDTH-1:0]          w_bitmap_nxt;
  logic [HASH_ISSUE_WIDTH*RESULT_W-1:0] w_slots_nxt;

  always_comb begin
    w_pop        = '0;
    w_delim_in   = 1'b0;
    w_dup        = 1'b0;
    w_bitmap_nxt = r_bitmap;
    w_slots_nxt  = r_slots;
    for (int i = 0; i < NUM_HASH_PE; i++) begin
      if (lane_hit[i]) begin
        w_pop      = w_pop + CW'(1);
        w_delim_in = w_delim_in | lane_delim[i];
        if (w_bitmap_nxt[lane_slot[i*W_LOG2 +: W_LOG2]]) w_dup = 1'b1;
        w_bitmap_nxt[lane_slot[i*W_LOG2 +: W_LOG2]] = 1'b1;
        w_slots_nxt[int'(lane_slot[i*W_LOG2 +: W_LOG2])*RESULT_W +: RESULT_W] =
          lane_result[i*RESULT_W +: RESULT_W];
      end
    end
    w_sum = {1'b0, r_count} + {1'b0, w_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= BANK_EMPTY;
      r_head   <= '0;
      r_count  <= '0;
      r_bitmap <= '0;
      r_delim  <= 1'b0;
      r_slots  <= '0;
    end else if (deq) begin
      r_state  <= BANK_EMPTY;
      r_count  <= '0;
      r_bitmap <= '0;
      r_delim  <= 1'b0;
    end else if (wr_en && (|lane_hit)) begin
      r_slots  <= w_slots_nxt;
      r_bitmap <= w_bitmap_nxt;
      r_delim  <= r_delim | w_delim_in;
      r_count  <= w_sum[CW-1:0];
      if (r_state == BANK_EMPTY) r_head <= req_head;
      // A single bundle may take an EMPTY bank straight to FULL.
      r_state  <= (w_sum == (CW+1)'(HASH_ISSUE_WIDTH)) ? BANK_FULL : BANK_FILLING;
    end
  end

  assign can_accept = (r_state == BANK_EMPTY) ||
                      ((r_state == BANK_FILLING) && (r_head == req_head));
  assign full       = (r_state == BANK_FULL);
  assign state      = r_state;
  assign head       = r_head;
  assign delim      = r_delim;
  assign result_vec = r_slots;

`ifndef SYNTHESIS
  a_no_dup_slot: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && w_dup));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && (|lane_hit) && (w_sum > (CW+1)'(HASH_ISSUE_WIDTH))));
`endif

endmodule : gather_window_bank
`default_nettype wire

// File: rtl/post_hash_pe_gatherer.sv
`default_nettype none
// ============================================================================
// Module      : post_hash_pe_gatherer
// Description : Collects per-lane hash-PE results into two address-indexed
//               window banks and emits whole windows in address order.
// Revision    : 1.0 - initial release
// ============================================================================
module post_hash_pe_gatherer
  import post_hash_pe_gatherer_pkg::*;
#(
  parameter int HASH_ISSUE_WIDTH = C_HASH_ISSUE_WIDTH,
  parameter int NUM_HASH_PE      = C_NUM_HASH_PE,
  parameter int ADDR_WIDTH       = C_ADDR_WIDTH,
  parameter int RESULT_W         = C_RESULT_W,
  localparam int W_LOG2          = $clog2(HASH_ISSUE_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 input_valid,
  input  logic [NUM_HASH_PE-1:0]               input_mask,
  input  logic [NUM_HASH_PE*ADDR_WIDTH-1:0]    input_addr,
  input  logic [NUM_HASH_PE*RESULT_W-1:0]      input_result,
  input  logic [NUM_HASH_PE-1:0]               input_delim,
  output logic                                 input_ready,
  output logic                                 output_valid,
  output logic [ADDR_WIDTH-1:0]                output_head_addr,
  output logic [HASH_ISSUE_WIDTH*RESULT_W-1:0] output_result_vec,
  output logic                                 output_delim,
  input  logic                                 output_ready
);

  logic [ADDR_WIDTH-1:0]             w_lane_addr [NUM_HASH_PE];
  logic [ADDR_WIDTH-1:0]             w_lane_head [NUM_HASH_PE];
  logic                              w_lane_bank [NUM_HASH_PE];
  logic [NUM_HASH_PE*W_LOG2-1:0]     w_lane_slot;

  logic [NUM_HASH_PE-1:0]            w_hit      [2];
  logic [ADDR_WIDTH-1:0]             w_req_head [2];
  logic                              w_can      [2];
  logic                              w_full     [2];
  logic [1:0]                        w_state    [2];
  logic [ADDR_WIDTH-1:0]             w_head     [2];
  logic                              w_delim    [2];
  logic [HASH_ISSUE_WIDTH*RESULT_W-1:0] w_vec   [2];
  logic                              w_deq      [2];

  logic [ADDR_WIDTH-1:0]             w_low_addr;
  logic                              w_low_bank;
  logic                              w_blocked;
  logic                              w_accept;
  logic                              w_out_hs;
  logic                              w_both_empty;
  logic                              r_rd;

  generate
    for (genvar i = 0; i < NUM_HASH_PE; i++) begin : g_lane
      assign w_lane_addr[i] = input_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_lane_head[i] = {w_lane_addr[i][ADDR_WIDTH-1:W_LOG2], {W_LOG2{1'b0}}};
      assign w_lane_bank[i] = w_lane_addr[i][W_LOG2];
      assign w_lane_slot[i*W_LOG2 +: W_LOG2] = w_lane_addr[i][W_LOG2-1:0];
    end
  endgenerate

  // Walk lanes high-to-low so the lowest masked lane sets each bank's head.
  always_comb begin
    w_hit[0]      = '0;
    w_hit[1]      = '0;
    w_req_head[0] = '0;
    w_req_head[1] = '0;
    w_low_addr    = '1;
    w_low_bank    = 1'b0;
    for (int i = NUM_HASH_PE - 1; i >= 0; i--) begin
      if (input_mask[i]) begin
        w_hit[w_lane_bank[i]][i] = 1'b1;
        w_req_head[w_lane_bank[i]] = w_lane_head[i];
        if (w_lane_addr[i] <= w_low_addr) begin
          w_low_addr = w_lane_addr[i];
          w_low_bank = w_lane_bank[i];
        end
      end
    end
  end

  assign w_blocked    = ((|w_hit[0]) && !w_can[0]) || ((|w_hit[1]) && !w_can[1]);
  assign input_ready  = !w_blocked;
  assign w_accept     = input_valid && input_ready;
  assign w_out_hs     = output_valid && output_ready;
  assign w_both_empty = (w_state[0] == BANK_EMPTY) && (w_state[1] == BANK_EMPTY);

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      assign w_deq[b] = w_out_hs && (r_rd == 1'(b));
      gather_window_bank #(
        .HASH_ISSUE_WIDTH (HASH_ISSUE_WIDTH),
        .NUM_HASH_PE      (NUM_HASH_PE),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .RESULT_W         (RESULT_W)
      ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (w_accept),
        .lane_hit    (w_hit[b]),
        .lane_slot   (w_lane_slot),
        .lane_result (input_result),
        .lane_delim  (input_delim),
        .req_head    (w_req_head[b]),
        .deq         (w_deq[b]),
        .can_accept  (w_can[b]),
        .full        (w_full[b]),
        .state       (w_state[b]),
        .head        (w_head[b]),
        .delim       (w_delim[b]),
        .result_vec  (w_vec[b])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= 1'b0;
    end else if (w_both_empty && w_accept && (|input_mask)) begin
      r_rd <= w_low_bank;
    end else if (w_out_hs) begin
      r_rd <= ~r_rd;
    end
  end

  assign output_valid      = w_full[r_rd];
  assign output_head_addr  = w_head[r_rd];
  assign output_result_vec = w_vec[r_rd];
  assign output_delim      = w_delim[r_rd];

`ifndef SYNTHESIS
  a_rd_order: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_full[~r_rd] && (w_state[r_rd] == BANK_EMPTY)));
`endif

endmodule : post_hash_pe_gatherer
`default_nettype wire
